// File: rtl/lm71_pkg.sv
// rtl/lm71_pkg.sv - shared types and constants for the LM71 temperature reader
package lm71_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    SHIFT    = 2'd2,
    CS_HOLD  = 2'd3
  } state_t;

  localparam int FRAME_W = 16;
  localparam int TEMP_W  = 14;

  // Low two bits of every LM71 read frame are driven high by the sensor
  localparam logic [1:0] STATUS_BITS = 2'b11;

endpackage

// File: rtl/lm71_sck_tick.sv
// rtl/lm71_sck_tick.sv - SCK half-period tick generator, held cleared while idle
module lm71_sck_tick #(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/lm71_temp_reader.sv
// rtl/lm71_temp_reader.sv - periodic LM71 SPI reader with valid/ready temperature port
// Define LM71_AVG_EN to output a 4-sample moving average of good frames.
module lm71_temp_reader
  import lm71_pkg::*;
#(
  parameter int CLK_DIV       = 5,
  parameter int PERIOD_CYCLES = 12_500_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              temp_cs_n,
  output logic              temp_sc,
  output logic              temp_mosi,
  input  logic              temp_miso,
  output logic [TEMP_W-1:0] temp_data,
  output logic              temp_valid,
  input  logic              temp_ready,
  output logic              overrun,
  output logic              frame_err
);

  localparam int            TW     = $clog2(PERIOD_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(PERIOD_CYCLES - 1);

  state_t              state, next_state;
  logic [TW-1:0]       timer;
  logic                tick;
  logic                sc_q;
  logic                shift_done;
  logic [3:0]          bit_cnt;
  logic [FRAME_W-1:0]  shift_reg;
  logic                eval;
  logic                frame_good;
  logic                accept;
  logic                load;
  logic [TEMP_W-1:0]   load_data;

  lm71_sck_tick #(.CLK_DIV(CLK_DIV)) u_sck_tick (
    .clk   (clk),
    .rst   (reset),
    .clear (state == IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (enable && timer == T_LAST) next_state = CS_SETUP;
      CS_SETUP: if (tick) next_state = SHIFT;
      // Trailing low half after the 16th falling edge keeps SCK quiet before CS rises
      SHIFT:    if (tick && !sc_q && shift_done) next_state = CS_HOLD;
      CS_HOLD:  if (tick) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    temp_cs_n = 1'b1;
    temp_sc   = 1'b0;
    temp_mosi = 1'b1;
    case (state)
      CS_SETUP: temp_cs_n = 1'b0;
      SHIFT: begin
        temp_cs_n = 1'b0;
        temp_sc   = sc_q;
      end
      default: ;
    endcase
  end

  // Free-running while enabled so frame starts are exactly PERIOD_CYCLES apart
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (!enable || timer == T_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc_q       <= 1'b0;
      shift_done <= 1'b0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      eval       <= 1'b0;
    end else begin
      eval <= (state == CS_HOLD) && tick;
      if (state != SHIFT) begin
        sc_q       <= 1'b0;
        shift_done <= 1'b0;
        bit_cnt    <= '0;
      end else if (tick) begin
        if (sc_q) begin
          sc_q <= 1'b0;
          if (bit_cnt == 4'd15) shift_done <= 1'b1;
          else                  bit_cnt    <= bit_cnt + 4'd1;
        end else if (!shift_done) begin
          sc_q      <= 1'b1;
          shift_reg <= {shift_reg[FRAME_W-2:0], temp_miso};
        end
      end
    end
  end

  assign frame_good = eval && (shift_reg[1:0] == STATUS_BITS);
  assign accept     = temp_valid && temp_ready;

`ifdef LM71_AVG_EN
  logic [TEMP_W-1:0]  hist [4];
  logic               primed;
  logic               avg_load;
  logic [FRAME_W-1:0] avg_sum;

  // First good frame after reset fills the whole window so the average starts settled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      primed   <= 1'b0;
      avg_load <= 1'b0;
      for (int i = 0; i < 4; i++) hist[i] <= '0;
    end else begin
      avg_load <= frame_good;
      if (frame_good) begin
        primed  <= 1'b1;
        hist[0] <= shift_reg[FRAME_W-1:2];
        for (int i = 1; i < 4; i++) hist[i] <= primed ? hist[i-1] : shift_reg[FRAME_W-1:2];
      end
    end
  end

  always_comb begin
    avg_sum = '0;
    for (int i = 0; i < 4; i++) begin
      avg_sum = avg_sum + {{(FRAME_W-TEMP_W){hist[i][TEMP_W-1]}}, hist[i]};
    end
  end

  assign load      = avg_load;
  assign load_data = avg_sum[FRAME_W-1:2];
`else
  assign load      = frame_good;
  assign load_data = shift_reg[FRAME_W-1:2];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      temp_data  <= '0;
      temp_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (eval) frame_err <= (shift_reg[1:0] != STATUS_BITS);
      if (load) begin
        temp_data  <= load_data;
        temp_valid <= 1'b1;
        if (accept)          overrun <= 1'b0;
        else if (temp_valid) overrun <= 1'b1;
      end else if (accept) begin
        temp_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lm71_temp_reader.sv
// tb/tb_lm71_temp_reader.sv - self-checking bench for lm71_temp_reader (CLK_DIV=2, PERIOD_CYCLES=200)
module tb_lm71_temp_reader;

  localparam int CLK_DIV = 2;
  localparam int PERIOD  = 200;
  localparam int CS_LOW  = 16 * 4 + 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        temp_ready = 1'b0;
  logic        temp_cs_n, temp_sc, temp_mosi, temp_miso;
  logic [13:0] temp_data;
  logic        temp_valid, overrun, frame_err;

  always #5 clk = ~clk;

  lm71_temp_reader #(.CLK_DIV(CLK_DIV), .PERIOD_CYCLES(PERIOD)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .temp_cs_n  (temp_cs_n),
    .temp_sc    (temp_sc),
    .temp_mosi  (temp_mosi),
    .temp_miso  (temp_miso),
    .temp_data  (temp_data),
    .temp_valid (temp_valid),
    .temp_ready (temp_ready),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sensor: MSB on CS fall, next bit after each SCK fall
  logic [15:0] sens_frame = 16'hFFFF;
  int          sidx = 16;
  logic        last_cs = 1'b1;
  always @(negedge temp_cs_n or posedge temp_cs_n or negedge temp_sc) begin
    if (!temp_cs_n) begin
      if (last_cs) sidx = 0;
      else         sidx++;
    end
    last_cs = temp_cs_n;
  end
  assign temp_miso = (sidx < 16) ? sens_frame[15 - sidx] : 1'b1;

  // Bus monitor sampled on the inactive edge
  int          cyc = 0, cs_falls = 0, cs_low = 0, sc_rises = 0, valid_cycles = 0;
  int          last_fall = 0, fall_gap = 0;
  logic        prev_cs = 1'b1, prev_sc = 1'b0;
  logic [13:0] acc_q[$];
  always @(negedge clk) begin
    cyc++;
    if (prev_cs && !temp_cs_n) begin
      cs_falls++;
      fall_gap     = cyc - last_fall;
      last_fall    = cyc;
      cs_low       = 0;
      sc_rises     = 0;
      valid_cycles = 0;
    end
    if (!temp_cs_n) cs_low++;
    if (!prev_sc && temp_sc) sc_rises++;
    if (temp_valid) valid_cycles++;
    if (temp_valid && temp_ready) acc_q.push_back(temp_data);
    prev_cs = temp_cs_n;
    prev_sc = temp_sc;
  end

  // Reference model: sample register state plus queue of expected accepted samples
  logic        m_valid = 1'b0, m_over = 1'b0, m_err = 1'b0;
  logic [13:0] m_data = '0;
  logic [13:0] exp_acc[$];
  int          acc_rd = 0;
`ifdef LM71_AVG_EN
  int          hq[$];
`endif

  task automatic model_reset();
    m_valid = 1'b0; m_over = 1'b0; m_err = 1'b0; m_data = '0;
    exp_acc.delete();
    acc_rd = acc_q.size();
`ifdef LM71_AVG_EN
    hq.delete();
`endif
  endtask

  task automatic model_temp(input logic [15:0] f, output logic [13:0] t);
`ifdef LM71_AVG_EN
    int v, s;
    v = $signed(f[15:2]);
    if (hq.size() == 0) begin
      repeat (4) hq.push_front(v);
    end else begin
      hq.push_front(v);
      void'(hq.pop_back());
    end
    s = 0;
    foreach (hq[i]) s += hq[i];
    s = s >>> 2;
    t = s[13:0];
`else
    t = f[15:2];
`endif
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state();
    chk("temp_valid", temp_valid, m_valid);
    chk("temp_data", temp_data, m_data);
    chk("overrun", overrun, m_over);
    chk("frame_err", frame_err, m_err);
    chk("accept_count", acc_q.size() - acc_rd, exp_acc.size());
    foreach (exp_acc[i]) if (acc_rd + i < acc_q.size()) chk("accept_data", acc_q[acc_rd + i], exp_acc[i]);
    acc_rd = acc_q.size();
    exp_acc.delete();
  endtask

  task automatic step(input logic [15:0] f, input logic r, input bit gap_chk, input bit drop_en);
    int          start, n;
    logic [13:0] e;
    sens_frame = f;
    temp_ready = r;
    if (r && m_valid) begin
      exp_acc.push_back(m_data);
      m_valid = 1'b0;
      m_over  = 1'b0;
    end
    start = cs_falls;
    n = 0;
    while (cs_falls == start && n < 3 * PERIOD) begin cyc1(); n++; end
    chk("frame_start", cs_falls - start, 1);
    if (drop_en) enable = 1'b0;
    n = 0;
    while (!temp_cs_n && n < 200) begin cyc1(); n++; end
    chk("frame_end", temp_cs_n, 1'b1);
    repeat (6) cyc1();
    if (f[1:0] == 2'b11) begin
      model_temp(f, e);
      m_err  = 1'b0;
      m_data = e;
      if (r) exp_acc.push_back(e);
      else begin
        if (m_valid) m_over = 1'b1;
        m_valid = 1'b1;
      end
    end else begin
      m_err = 1'b1;
    end
    chk("sc_rises", sc_rises, 16);
    chk("cs_low_cycles", cs_low, CS_LOW);
    if (gap_chk) chk("frame_period", fall_gap, PERIOD);
    check_state();
  endtask

  typedef struct {
    logic [15:0] frame;
    logic        ready;
    logic [13:0] data;
    logic        valid;
    logic        over;
    logic        err;
  } vec_t;

  initial begin
    vec_t        tbl[$];
    logic [15:0] f;
    logic        r;
    int          start, n;

`ifdef LM71_AVG_EN
    tbl.push_back('{16'h0C83, 1'b1, 14'h0320, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{16'h0D03, 1'b1, 14'h0328, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{16'h0D03, 1'b1, 14'h0330, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{16'h0D03, 1'b1, 14'h0338, 1'b0, 1'b0, 1'b0});
`else
    tbl.push_back('{16'h0C83, 1'b1, 14'h0320, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{16'hF383, 1'b1, 14'h3CE0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{16'h0C83, 1'b0, 14'h0320, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{16'h0D03, 1'b0, 14'h0340, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{16'h0C80, 1'b0, 14'h0340, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{16'h0C83, 1'b1, 14'h0320, 1'b0, 1'b0, 1'b0});
`endif

    repeat (3) cyc1();
    chk("rst_cs_n", temp_cs_n, 1'b1);
    chk("rst_sc", temp_sc, 1'b0);
    chk("rst_mosi", temp_mosi, 1'b1);
    chk("rst_data", temp_data, 14'h0);
    chk("rst_valid", temp_valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);

    reset  = 1'b0;
    enable = 1'b1;
    model_reset();

    foreach (tbl[i]) begin
      step(tbl[i].frame, tbl[i].ready, i > 0, 1'b0);
      chk("tbl_data", temp_data, tbl[i].data);
      chk("tbl_valid", temp_valid, tbl[i].valid);
      chk("tbl_overrun", overrun, tbl[i].over);
      chk("tbl_frame_err", frame_err, tbl[i].err);
      if (tbl[i].ready) chk("tbl_valid_one_cycle", valid_cycles, 1);
    end

    // Two unconsumed samples, then a single-cycle ready pulse drains them
    step(16'h0C83, 1'b0, 1'b1, 1'b0);
    step(16'h0D03, 1'b0, 1'b1, 1'b0);
    chk("ovr_set", overrun, 1'b1);
    temp_ready = 1'b1;
    cyc1();
    temp_ready = 1'b0;
    exp_acc.push_back(m_data);
    m_valid = 1'b0;
    m_over  = 1'b0;
    check_state();

    for (int k = 0; k < 8; k++) begin
      f = 16'($urandom);
      if ($urandom_range(0, 3) != 0) f[1:0] = 2'b11;
      r = 1'($urandom_range(0, 1));
      step(f, r, 1'b1, 1'b0);
    end

    // Reset asserted while bit 7 is being clocked
    sens_frame = 16'h0D03;
    temp_ready = 1'b0;
    start = cs_falls;
    n = 0;
    while (cs_falls == start && n < 3 * PERIOD) begin cyc1(); n++; end
    n = 0;
    while (sc_rises < 8 && n < 200) begin cyc1(); n++; end
    chk("bit7_reached", sc_rises, 8);
    reset = 1'b1;
    #1;
    chk("midrst_cs_n", temp_cs_n, 1'b1);
    chk("midrst_sc", temp_sc, 1'b0);
    chk("midrst_valid", temp_valid, 1'b0);
    chk("midrst_overrun", overrun, 1'b0);
    chk("midrst_data", temp_data, 14'h0);
    cyc1();
    reset = 1'b0;
    model_reset();
    repeat (100) cyc1();
    check_state();

    // enable dropped mid-frame: that frame lands, no further frames start
    step(16'h0D03, 1'b0, 1'b0, 1'b1);
    chk("en_off_data", temp_data, 14'h0340);
    start = cs_falls;
    repeat (3 * PERIOD) cyc1();
    chk("no_restart", cs_falls - start, 0);
    chk("idle_cs_n", temp_cs_n, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
